// File: rtl/sound_cue_arbiter.sv
// sound_cue_arbiter: shares one sound-board interface (snd_reset + 6-bit selection)
// among N_REQ requesters. Strobes are captured into per-requester pending flags and
// served in fixed priority (index 0 highest) as a reset pulse, hold, and silent gap.
module sound_cue_arbiter #(
    parameter int N_REQ       = 4,
    parameter int CNT_W       = 24,
    parameter int RST_CYCLES  = 1000,
    parameter int HOLD_CYCLES = 2000000,
    parameter int GAP_CYCLES  = 500,
    parameter int PREEMPT     = 1
) (
    input  logic               PCLK,
    input  logic               PRESERN,
    input  logic [N_REQ-1:0]   req_pulse,
    input  logic [6*N_REQ-1:0] req_cue,
    output logic               snd_reset,
    output logic [5:0]         snd_selection,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               dropped
);

    localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [5:0] SEL_IDLE = 6'b111111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // input capture stage, pending flags and stored cue codes
    logic [N_REQ-1:0]   r_cap_pulse;
    logic [6*N_REQ-1:0] r_cap_cue;
    logic [N_REQ-1:0]   r_pending;
    logic [6*N_REQ-1:0] r_cue_q;
    logic               r_dropped;

    // sequencer state and registered board outputs
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [OWN_W-1:0]   r_owner;
    logic               r_snd_reset;
    logic [5:0]         r_sel;
    logic [N_REQ-1:0]   r_grant;

    logic [N_REQ-1:0]   w_pending_next;
    logic [6*N_REQ-1:0] w_cue_next;
    logic [N_REQ-1:0]   w_clear;
    logic               w_pick_any;
    logic [OWN_W-1:0]   w_pick_idx;
    logic [5:0]         w_pick_cue;
    logic               w_start;
    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [OWN_W-1:0]   w_owner_next;
    logic               w_snd_reset_next;
    logic [5:0]         w_sel_next;
    logic [N_REQ-1:0]   w_grant_next;

    // A fresh strobe always wins over the arbiter clearing the same requester.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_pending_next[gi] = r_cap_pulse[gi] | (r_pending[gi] & ~w_clear[gi]);
            assign w_cue_next[6*gi +: 6] = r_cap_pulse[gi] ? r_cap_cue[6*gi +: 6]
                                                             : r_cue_q[6*gi +: 6];
        end
    endgenerate

    // Find the lowest-index (highest-priority) pending requester and its cue.
    always_comb begin
        w_pick_any = 1'b0;
        w_pick_idx = '0;
        w_pick_cue = SEL_IDLE;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_pick_any = 1'b1;
                w_pick_idx = OWN_W'(i);
                w_pick_cue = r_cue_q[6*i +: 6];
            end
        end
    end

    // Next-state and next-output logic of the playback sequencer.
    always_comb begin
        w_state_next     = r_state;
        w_cnt_next       = r_cnt;
        w_owner_next     = r_owner;
        w_snd_reset_next = r_snd_reset;
        w_sel_next       = r_sel;
        w_grant_next     = r_grant;
        w_start          = 1'b0;
        w_clear          = '0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_any) w_start = 1'b1;
            end
            S_RST: begin
                if (r_cnt == '0) begin
                    w_snd_reset_next = 1'b0;
                    w_cnt_next       = CNT_W'(HOLD_CYCLES - 1);
                    w_state_next     = S_PLAY;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_PLAY: begin
                // a higher-priority request aborts this cue; the aborted cue is lost
                if ((PREEMPT != 0) && w_pick_any && (w_pick_idx < r_owner)) begin
                    w_start = 1'b1;
                end else if (r_cnt == '0) begin
                    w_sel_next   = SEL_IDLE;
                    w_grant_next = '0;
                    w_cnt_next   = CNT_W'(GAP_CYCLES - 1);
                    w_state_next = S_GAP;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_start) begin
            w_clear          = N_REQ'(1) << w_pick_idx;
            w_owner_next     = w_pick_idx;
            w_sel_next       = w_pick_cue;
            w_snd_reset_next = 1'b1;
            w_grant_next     = N_REQ'(1) << w_pick_idx;
            w_cnt_next       = CNT_W'(RST_CYCLES - 1);
            w_state_next     = S_RST;
        end
    end

    // All state registers; reset aborts any cue in progress immediately.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_cap_pulse <= '0;
            r_cap_cue   <= '0;
            r_pending   <= '0;
            r_cue_q     <= '0;
            r_dropped   <= 1'b0;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_owner     <= '0;
            r_snd_reset <= 1'b0;
            r_sel       <= SEL_IDLE;
            r_grant     <= '0;
        end else begin
            r_cap_pulse <= req_pulse;
            r_cap_cue   <= req_cue;
            r_pending   <= w_pending_next;
            r_cue_q     <= w_cue_next;
            r_dropped   <= |(r_cap_pulse & r_pending);
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_owner     <= w_owner_next;
            r_snd_reset <= w_snd_reset_next;
            r_sel       <= w_sel_next;
            r_grant     <= w_grant_next;
        end
    end

    assign snd_reset     = r_snd_reset;
    assign snd_selection = r_sel;
    assign grant         = r_grant;
    assign busy          = (r_state != S_IDLE);
    assign dropped       = r_dropped;

endmodule
